// File: rtl/bigmul_result_streamer_if.sv
`default_nettype none
// ============================================================================
// Module      : bigmul_result_streamer_if
// Description : Bus bundle for the big-multiplier result streamer.
//               Carries the synchronous result-memory read port
//               (rd_en / rd_addr / rd_data) and the outgoing valid/ready
//               word stream (m_valid / m_ready / m_data / m_index / m_last).
//               master : streamer side (drives reads and the stream)
//               slave  : memory + downstream side
// Revision    : 1.0 - initial release
// ============================================================================
interface bigmul_result_streamer_if #(
    parameter int WORD_W = 64,
    parameter int ADDR_W = 7
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [WORD_W-1:0] rd_data;

    logic              m_valid;
    logic              m_ready;
    logic [WORD_W-1:0] m_data;
    logic [ADDR_W-1:0] m_index;
    logic              m_last;

    modport master (
        output rd_en, rd_addr,
        input  rd_data,
        output m_valid, m_data, m_index, m_last,
        input  m_ready
    );

    modport slave (
        input  rd_en, rd_addr,
        output rd_data,
        input  m_valid, m_data, m_index, m_last,
        output m_ready
    );
endinterface
`default_nettype wire

// File: rtl/bigmul_result_streamer.sv
`default_nettype none
// ============================================================================
// Module      : bigmul_result_streamer
// Description : Drains the multiplier's result memory through a 1-cycle
//               latency synchronous read port and streams the words out,
//               least-significant first, on a valid/ready interface.
//               A 2-entry skid FIFO hides the read latency so one word per
//               cycle is sustained and backpressure never drops a word.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               start           - pulse to begin a drain (ignored when busy)
//               busy            - drain in progress
//               drain_done      - one-cycle pulse after the final handshake
//               bus (master)    - read port + output stream
// Revision    : 1.0 - initial release
// ============================================================================
module bigmul_result_streamer #(
    parameter int WORD_W    = 64,
    parameter int NUM_WORDS = 128,
    parameter int ADDR_W    = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     drain_done,
    bigmul_result_streamer_if.master bus
);

    localparam int CNT_W = ADDR_W + 1;

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_stream = 2'd1;
    localparam logic [1:0] c_st_done   = 2'd2;

    localparam logic [CNT_W-1:0]  c_num_words = CNT_W'(NUM_WORDS);
    localparam logic [ADDR_W-1:0] c_last_idx  = ADDR_W'(NUM_WORDS - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;

    logic [CNT_W-1:0]  r_issue_cnt;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_inflight_idx;

    logic [WORD_W-1:0] r_fifo_data [0:1];
    logic [ADDR_W-1:0] r_fifo_idx  [0:1];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_fifo_cnt;

    logic              w_rd_en;
    logic              w_pop;
    logic              w_head_last;
    logic [2:0]        w_occupancy;

    // ------------------------------------------------------------------
    // Stream side: the FIFO head is the output register.
    // ------------------------------------------------------------------
    assign bus.m_valid = (r_fifo_cnt != 2'd0);
    assign bus.m_data  = r_fifo_data[r_rd_ptr];
    assign bus.m_index = r_fifo_idx[r_rd_ptr];
    assign w_head_last = (r_fifo_idx[r_rd_ptr] == c_last_idx);
    assign bus.m_last  = bus.m_valid & w_head_last;
    assign w_pop       = bus.m_valid & bus.m_ready;

    // Words already held plus the one returning from memory, less the one
    // leaving this cycle. Keeping this below 2 before issuing guarantees the
    // returning word always finds a free slot.
    assign w_occupancy = {1'b0, r_fifo_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};

    // Once every word has been issued the address holds at the last one
    // instead of wrapping back to zero.
    assign bus.rd_en   = w_rd_en;
    assign bus.rd_addr = (r_issue_cnt >= c_num_words) ? c_last_idx
                                                      : r_issue_cnt[ADDR_W-1:0];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:   if (start) w_state_nxt = c_st_stream;
            c_st_stream: if (w_pop && w_head_last) w_state_nxt = c_st_done;
            c_st_done:   w_state_nxt = c_st_idle;
            default:     w_state_nxt = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy       = 1'b0;
        drain_done = 1'b0;
        w_rd_en    = 1'b0;
        case (r_state)
            c_st_stream: begin
                busy    = 1'b1;
                w_rd_en = (r_issue_cnt < c_num_words) && (w_occupancy < 3'd2);
            end
            c_st_done:   drain_done = 1'b1;
            default:     ;
        endcase
    end

    // ------------------------------------------------------------------
    // Read issue, in-flight tracking and skid FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_issue_cnt    <= '0;
            r_inflight     <= 1'b0;
            r_inflight_idx <= '0;
            r_fifo_data[0] <= '0;
            r_fifo_data[1] <= '0;
            r_fifo_idx[0]  <= '0;
            r_fifo_idx[1]  <= '0;
            r_wr_ptr       <= 1'b0;
            r_rd_ptr       <= 1'b0;
            r_fifo_cnt     <= 2'd0;
        end else begin
            if ((r_state == c_st_idle) && start) begin
                r_issue_cnt <= '0;
            end else if (w_rd_en) begin
                r_issue_cnt <= r_issue_cnt + CNT_W'(1);
            end

            // rd_data is valid exactly one cycle after its strobe.
            r_inflight <= w_rd_en;
            if (w_rd_en) begin
                r_inflight_idx <= r_issue_cnt[ADDR_W-1:0];
            end

            if (r_inflight) begin
                r_fifo_data[r_wr_ptr] <= bus.rd_data;
                r_fifo_idx[r_wr_ptr]  <= r_inflight_idx;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_fifo_cnt <= r_fifo_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bigmul_result_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bigmul_result_streamer
// Description : Self-checking scoreboard bench for bigmul_result_streamer.
//               A behavioural result memory answers reads; each accepted
//               start pushes the full expected word sequence into a queue,
//               and a negedge monitor pops and compares on every handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bigmul_result_streamer;

    localparam int WORD_W    = 64;
    localparam int NUM_WORDS = 128;
    localparam int ADDR_W    = 7;

    typedef struct packed {
        logic [WORD_W-1:0] d;
        logic [ADDR_W-1:0] idx;
        logic              last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy;
    logic drain_done;

    bigmul_result_streamer_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();

    bigmul_result_streamer #(
        .WORD_W   (WORD_W),
        .NUM_WORDS(NUM_WORDS),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .drain_done(drain_done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Behavioural result memory: one-cycle synchronous read.
    logic [WORD_W-1:0] mem [NUM_WORDS];
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    end

    // Downstream ready pattern: 0 = always, 1 = toggle, 2 = random, 3 = never.
    int   ready_mode = 0;
    logic tog = 1'b0;
    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            tog = ~tog;
            case (ready_mode)
                0:       bus.m_ready = 1'b1;
                1:       bus.m_ready = tog;
                2:       bus.m_ready = ($urandom_range(0, 3) != 0);
                default: bus.m_ready = 1'b0;
            endcase
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   compared   = 0;
    int   mismatched = 0;
    exp_t q[$];

    task automatic chk(input string name, input logic [WORD_W-1:0] act,
                       input logic [WORD_W-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    bit                expect_done = 0;
    bit                prev_stall  = 0;
    logic [WORD_W-1:0] prev_d;
    logic [ADDR_W-1:0] prev_idx;
    logic              prev_last;
    int                outstanding = 0;
    int                rd_cnt      = 0;
    int                words_cnt   = 0;
    int                done_cnt    = 0;
    int                done_edge   = 0;
    int                first_hs_edge = 0;
    bit                first_seen  = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            expect_done = 0;
            prev_stall  = 0;
            outstanding = 0;
        end else begin
            chk("drain_done", {63'd0, drain_done}, {63'd0, expect_done});
            expect_done = 0;
            if (drain_done) begin
                done_cnt++;
                done_edge = cyc;
                chk("busy_at_done", {63'd0, busy}, 64'd0);
            end
            if (bus.rd_en) rd_cnt++;
            if (outstanding > 2) chk("occupancy", 64'(outstanding), 64'd2);
            if (prev_stall) begin
                chk("stall_valid", {63'd0, bus.m_valid}, 64'd1);
                chk("stall_data", bus.m_data, prev_d);
                chk("stall_index", {57'd0, bus.m_index}, {57'd0, prev_idx});
                chk("stall_last", {63'd0, bus.m_last}, {63'd0, prev_last});
            end
            if (bus.m_valid && bus.m_ready) begin
                if (q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_word: got index %0d expected none", bus.m_index);
                end else begin
                    e = q.pop_front();
                    chk("word_data", bus.m_data, e.d);
                    chk("word_index", {57'd0, bus.m_index}, {57'd0, e.idx});
                    chk("word_last", {63'd0, bus.m_last}, {63'd0, e.last});
                    if (e.last) expect_done = 1;
                end
                words_cnt++;
                if (!first_seen) begin
                    first_seen    = 1;
                    first_hs_edge = cyc + 1;
                end
            end
            outstanding = outstanding + (bus.rd_en ? 1 : 0)
                        - ((bus.m_valid && bus.m_ready) ? 1 : 0);
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_d     = bus.m_data;
            prev_idx   = bus.m_index;
            prev_last  = bus.m_last;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    int start_edge = 0;

    task automatic clear_stats();
        rd_cnt     = 0;
        words_cnt  = 0;
        first_seen = 0;
    endtask

    // Pulse start; when expect_accept is set the whole drain is predicted.
    task automatic pulse_start(input bit expect_accept);
        @(posedge clk); #1;
        start = 1'b1;
        start_edge = cyc + 1;
        if (expect_accept) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                exp_t e;
                e.d    = mem[i];
                e.idx  = ADDR_W'(i);
                e.last = (i == NUM_WORDS - 1);
                q.push_back(e);
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int c = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        if (done_cnt == d0) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: got no drain_done expected one within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_words(input int n, input int budget);
        int c = 0;
        while (words_cnt < n && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        if (words_cnt < n) begin
            compared++;
            mismatched++;
            $display("FAIL words_timeout: got %0d words expected %0d", words_cnt, n);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_busy"},    {63'd0, busy}, 64'd0);
        chk({tag, "_done"},    {63'd0, drain_done}, 64'd0);
        chk({tag, "_rd_en"},   {63'd0, bus.rd_en}, 64'd0);
        chk({tag, "_rd_addr"}, {57'd0, bus.rd_addr}, 64'd0);
        chk({tag, "_m_valid"}, {63'd0, bus.m_valid}, 64'd0);
        chk({tag, "_m_data"},  bus.m_data, 64'd0);
        chk({tag, "_m_index"}, {57'd0, bus.m_index}, 64'd0);
        chk({tag, "_m_last"},  {63'd0, bus.m_last}, 64'd0);
    endtask

    task automatic check_drain(input string tag, input int d0);
        @(posedge clk); #1;
        chk({tag, "_words"},  64'(words_cnt), 64'(NUM_WORDS));
        chk({tag, "_reads"},  64'(rd_cnt), 64'(NUM_WORDS));
        chk({tag, "_dones"},  64'(done_cnt - d0), 64'd1);
        chk({tag, "_qempty"}, 64'(q.size()), 64'd0);
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int d0;
        int rd_before;

        for (int i = 0; i < NUM_WORDS; i++) mem[i] = '0;

        // 1. Reset held 3 cycles with start asserted: start must be ignored.
        rst = 1'b1; start = 1'b1; ready_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0;
        clear_stats();
        check_reset_outputs("reset");
        repeat (5) @(posedge clk);
        #1;
        chk("reset_no_reads", 64'(rd_cnt), 64'd0);
        chk("reset_idle", {63'd0, busy}, 64'd0);

        // 2. Full-throughput drain with exact latency checks.
        for (int i = 0; i < NUM_WORDS; i++) mem[i] = 64'h1000_0000_0000_0000 + 64'(i);
        clear_stats();
        d0 = done_cnt;
        pulse_start(1);
        wait_done(400, "full");
        chk("full_first_edge", 64'(first_hs_edge), 64'(start_edge + 3));
        chk("full_done_edge", 64'(done_edge), 64'(start_edge + NUM_WORDS + 2));
        check_drain("full", d0);

        // 3. Periodic backpressure.
        for (int i = 0; i < NUM_WORDS; i++) mem[i] = {56'h7F_FFFF_FFFF_FFFF, 8'(i)};
        clear_stats();
        d0 = done_cnt;
        ready_mode = 1;
        pulse_start(1);
        wait_done(800, "toggle");
        check_drain("toggle", d0);

        // 4. Long stall right after the first word appears.
        for (int i = 0; i < NUM_WORDS; i++) mem[i] = {$urandom, $urandom};
        clear_stats();
        d0 = done_cnt;
        ready_mode = 3;
        pulse_start(1);
        for (int c = 0; c < 10 && !bus.m_valid; c++) begin
            @(posedge clk); #3;
        end
        chk("stall_first_valid", {63'd0, bus.m_valid}, 64'd1);
        rd_before = rd_cnt;
        repeat (20) @(posedge clk);
        #1;
        chk("stall_reads_bounded", {63'd0, (rd_cnt - rd_before) <= 2}, 64'd1);
        ready_mode = 0;
        wait_done(400, "stall");
        check_drain("stall", d0);

        // 5a. Start while busy is ignored.
        for (int i = 0; i < NUM_WORDS; i++) mem[i] = {$urandom, $urandom};
        clear_stats();
        d0 = done_cnt;
        ready_mode = 0;
        pulse_start(1);
        wait_words(40, 200);
        pulse_start(0);
        wait_done(400, "busy_start");
        check_drain("busy_start", d0);
        repeat (5) @(posedge clk);
        #1;
        chk("busy_start_single_done", 64'(done_cnt - d0), 64'd1);

        // 5b. Reset mid-drain, then a clean drain from index 0.
        clear_stats();
        d0 = done_cnt;
        ready_mode = 2;
        pulse_start(1);
        wait_words(50, 400);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ready_mode = 0;
        check_reset_outputs("midreset");
        repeat (4) @(posedge clk);
        #1;
        chk("midreset_no_done", 64'(done_cnt - d0), 64'd0);

        for (int i = 0; i < NUM_WORDS; i++) mem[i] = {$urandom, $urandom};
        clear_stats();
        d0 = done_cnt;
        ready_mode = 2;
        pulse_start(1);
        wait_done(1000, "after_reset");
        check_drain("after_reset", d0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
